// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Owns the architectural PC and runs a single-outstanding fetch
//             handshake to instruction memory, holding each fetched word for
//             decode. Branch/jump redirects from execute replace the PC and
//             squash any response that was made stale by the redirect.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_pulse
);

    localparam logic [1:0]      c_st_idle = 2'd0;
    localparam logic [1:0]      c_st_req  = 2'd1;
    localparam logic [1:0]      c_st_wait = 2'd2;
    localparam logic [1:0]      c_st_hold = 2'd3;
    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;
    logic [XLEN-1:0] r_inst_data;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_misalign;

    logic [XLEN-1:0] w_redirect_target;
    logic            w_redirect_misaligned;

    // Redirect targets are word-aligned by dropping the low two address bits.
    assign w_redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_redirect_misaligned = |redirect_pc[1:0];

    // Sequencer: state, PC, stale-response flag and the decode holding register.
    // Redirects win over every normal transition except in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst_data <= '0;
            r_inst_pc   <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_state <= c_st_req;
                end
                c_st_req: begin
                    if (redirect_valid) begin
                        r_pc       <= w_redirect_target;
                        r_misalign <= w_redirect_misaligned;
                        // A request accepted alongside the redirect targets the
                        // old PC, so its response must be thrown away.
                        if (imem_req_ready) begin
                            r_drop  <= 1'b1;
                            r_state <= c_st_wait;
                        end
                    end else if (imem_req_ready) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (redirect_valid) begin
                        r_pc       <= w_redirect_target;
                        r_misalign <= w_redirect_misaligned;
                        if (imem_rsp_valid) begin
                            // Response consumed and discarded right now.
                            r_drop  <= 1'b0;
                            r_state <= c_st_req;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= c_st_req;
                        end else begin
                            r_inst_data <= imem_rsp_data;
                            r_inst_pc   <= r_pc;
                            r_pc        <= r_pc + c_pc_step;
                            r_state     <= c_st_hold;
                        end
                    end
                end
                c_st_hold: begin
                    if (redirect_valid) begin
                        // Held instruction is squashed even if decode takes it.
                        r_pc       <= w_redirect_target;
                        r_misalign <= w_redirect_misaligned;
                        r_state    <= c_st_req;
                    end else if (inst_ready) begin
                        r_state <= c_st_req;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Outputs come from registers only; the address is masked outside REQ so
    // every output reads zero while reset holds the machine in IDLE.
    assign imem_req_valid = (r_state == c_st_req);
    assign imem_req_addr  = (r_state == c_st_req) ? r_pc : '0;
    assign inst_valid     = (r_state == c_st_hold);
    assign inst_data      = r_inst_data;
    assign inst_pc        = r_inst_pc;
    assign misalign_pulse = r_misalign;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter and the instruction-memory fetch handshake for the core.
- Holds the architectural PC and issues one fetch request at a time to instruction memory over a valid/ready request channel, then takes the response.
- Passes the fetched instruction and its PC to decode over a valid/ready channel.
- Branch/jump redirects from execute replace the PC. Any in-flight response made stale by a redirect is squashed.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- XLEN, 32, address/instruction width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  target address for redirect
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address (= pc register)
- imem_rsp_valid  in  1  response data valid; at most one per accepted request, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  32  held instruction
- inst_pc  out  32  PC of held instruction
- misalign_pulse  out  1  one-cycle pulse when redirect_pc[1:0] != 0

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, drop=0, inst_data=0, inst_pc=0, misalign_pulse=0. All outputs are 0 while reset is asserted.
- States and outputs:
  - IDLE: no outputs asserted.
  - REQ: imem_req_valid=1, imem_req_addr=pc.
  - WAIT: no outputs asserted.
  - HOLD: inst_valid=1.
  - imem_req_valid and inst_valid are decoded from state only. There is no combinational path from any input to any output.
- IDLE → REQ unconditionally on the first clock after reset deasserts.
- REQ:
  - If imem_req_ready, go to WAIT.
  - If imem_req_valid is not accepted, it stays high and imem_req_addr stays stable until accepted or redirected.
- WAIT, on imem_rsp_valid:
  - If drop=0: inst_data<=imem_rsp_data, inst_pc<=pc, pc<=pc+4, go to HOLD.
  - If drop=1: discard the data, clear drop, go to REQ.
- HOLD: on inst_ready, go to REQ. The handshake completes on the cycle inst_valid && inst_ready.
- Redirect (redirect_valid=1) has priority over normal transitions in every state except IDLE, where it is ignored.
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - misalign_pulse=1 for one cycle if redirect_pc[1:0] != 0.
- Redirect in REQ:
  - Without imem_req_ready: stay in REQ with the new pc.
  - With imem_req_ready in the same cycle: the accepted request is stale. Set drop=1 and go to WAIT.
- Redirect in WAIT:
  - Without imem_rsp_valid: set drop=1, stay in WAIT.
  - With imem_rsp_valid in the same cycle: discard the response and go to REQ; drop stays 0.
- Redirect in HOLD: the held instruction is squashed; inst_valid=0 next cycle, go to REQ. This applies even if inst_ready=1 in the same cycle; the handshake does not count as a transfer.
- Arithmetic:
  - pc+4 wraps modulo 2^32, so 32'hFFFF_FFFC → 32'h0000_0000.
  - inst_pc and inst_data are stable for the entire HOLD interval.
- At most one request is outstanding. No new request is issued while in WAIT.
- Reset mid-operation: immediate return to IDLE with the reset values. A response arriving after reset with no request accepted since reset is ignored (state is not WAIT).
- Throughput: at most 1 instruction per 3 cycles (REQ, WAIT, HOLD) with a zero-wait memory.

Test Plan:
1. Reset release, imem_req_ready=1 and 1-cycle response latency, inst_ready always 1.
   - Required: imem_req_addr sequence 0x0, 0x4, 0x8.
   - Required: inst_pc 0x0, 0x4, 0x8.
   - Required: first inst_valid on cycle 4 after reset release.
2. imem_req_ready held 0 for 3 cycles.
   - Required: imem_req_valid=1 and imem_req_addr constant at 0x0 throughout; request accepted on the 4th cycle.
3. Redirect to 0x100 while in WAIT, response arrives 2 cycles later with 0xDEADBEEF.
   - Required: response discarded and inst_valid never asserted for it.
   - Required: next imem_req_addr=0x100.
4. Redirect to 0x200 in HOLD with inst_ready=1 in the same cycle.
   - Required: inst_valid drops next cycle and next imem_req_addr=0x200.
5. Redirect to 0x303.
   - Required: misalign_pulse=1 for exactly one cycle and next imem_req_addr=0x300.
6. RESET_PC=32'hFFFF_FFFC with normal fetch.
   - Required: second imem_req_addr=0x0.
   - Then reset asserted during WAIT: all outputs 0 immediately, and the restart fetches from 0xFFFF_FFFC.
